// File: rtl/vga_pkg.sv
// Shared VGA types and helpers: timing records, RGB565 pixels, analyzer states and the CRC-16 step.
package vga_pkg;

  localparam int unsigned TIMING_WIDTH = 12;
  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  typedef struct packed {
    logic [TIMING_WIDTH-1:0] visible_area;
    logic [TIMING_WIDTH-1:0] front_porch;
    logic [TIMING_WIDTH-1:0] sync_pulse;
    logic [TIMING_WIDTH-1:0] back_porch;
  } line_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } vga_data_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_WAIT_VS,
    A_ACTIVE
  } analyzer_state_e;

  // CCITT CRC-16, one full 16-bit word per call, MSB first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_line_meter.sv
// Per-frame line geometry: de edge detection, pixel/line counters, first line length, ragged-line flag.
module vga_line_meter
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W = TIMING_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic             de_i,
  output logic [CNT_W-1:0] line_cnt_c,
  output logic [CNT_W-1:0] first_len_c,
  output logic             len_err_c
);

  logic             de_q;
  logic             de_fall;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] pix_cnt_nxt;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] first_len;
  logic             len_err;

  // The _c values already include a line closing this cycle, so a publish sees it.
  always_comb begin
    de_fall     = ~de_i & de_q;
    line_cnt_c  = line_cnt;
    first_len_c = first_len;
    len_err_c   = len_err;
    pix_cnt_nxt = pix_cnt;
    if (de_fall) begin
      pix_cnt_nxt = '0;
      if (line_cnt != '1) line_cnt_c = line_cnt + CNT_W'(1);
      if (line_cnt == '0)            first_len_c = pix_cnt;
      else if (pix_cnt != first_len) len_err_c   = 1'b1;
    end else if (de_i && (pix_cnt != '1)) begin
      pix_cnt_nxt = pix_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_q      <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      first_len <= '0;
      len_err   <= 1'b0;
    end else begin
      de_q <= de_i;
      if (clr_i || !run_i) begin
        pix_cnt   <= '0;
        line_cnt  <= '0;
        first_len <= '0;
        len_err   <= 1'b0;
      end else begin
        pix_cnt   <= pix_cnt_nxt;
        line_cnt  <= line_cnt_c;
        first_len <= first_len_c;
        len_err   <= len_err_c;
      end
    end
  end

endmodule

// File: rtl/vga_frame_analyzer.sv
// Sink-side frame checker: measures active width/height, CRC-16 per frame and timing errors,
// publishing results on each vsync rising edge.
module vga_frame_analyzer
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W  = TIMING_WIDTH,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  line_t             h_line_i,
  input  line_t             v_line_i,
  input  logic              vs_i,
  input  logic              de_i,
  input  vga_data_t         data_i,
  output logic [CNT_W-1:0]  width_o,
  output logic [CNT_W-1:0]  height_o,
  output logic [15:0]       crc_o,
  output logic              crc_match_o,
  output logic              timing_err_o,
  output logic [FCNT_W-1:0] frame_cnt_o,
  output logic              frame_done_o
);

  analyzer_state_e  state;
  logic             vs_q;
  logic [15:0]      crc;
  logic             proto_err;
  logic             first_pub;
  logic             vs_edge;
  logic             publish;
  logic             run;
  logic [CNT_W-1:0] line_cnt_c;
  logic [CNT_W-1:0] first_len_c;
  logic             len_err_c;
  logic             unused_timing_bits;

  assign vs_edge = vs_i & ~vs_q;
  assign run     = (state == A_ACTIVE) && enable_i;
  assign publish = run && vs_edge;

  // Only the visible areas matter here; the porch/sync fields are deliberately ignored.
  assign unused_timing_bits = ^{h_line_i, v_line_i};

  vga_line_meter #(.CNT_W(CNT_W)) u_line_meter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .run_i      (run),
    .clr_i      (vs_edge),
    .de_i       (de_i),
    .line_cnt_c (line_cnt_c),
    .first_len_c(first_len_c),
    .len_err_c  (len_err_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= A_IDLE;
      vs_q         <= 1'b0;
      crc          <= CRC16_INIT;
      proto_err    <= 1'b0;
      first_pub    <= 1'b1;
      width_o      <= '0;
      height_o     <= '0;
      crc_o        <= '0;
      crc_match_o  <= 1'b0;
      timing_err_o <= 1'b0;
      frame_cnt_o  <= '0;
      frame_done_o <= 1'b0;
    end else begin
      vs_q         <= vs_i;
      frame_done_o <= 1'b0;
      case (state)
        A_IDLE: begin
          proto_err <= 1'b0;
          crc       <= CRC16_INIT;
          if (enable_i) state <= A_WAIT_VS;
        end
        A_WAIT_VS: begin
          proto_err <= 1'b0;
          crc       <= CRC16_INIT;
          if (vs_edge) begin
            state     <= A_ACTIVE;
            proto_err <= de_i;
          end
        end
        A_ACTIVE: begin
          if (vs_edge) begin
            // A pixel present in the edge cycle is dropped and taints the new frame.
            width_o      <= first_len_c;
            height_o     <= line_cnt_c;
            crc_o        <= crc;
            crc_match_o  <= ~first_pub && (crc == crc_o);
            timing_err_o <= len_err_c | proto_err
                          | (first_len_c != CNT_W'(h_line_i.visible_area))
                          | (line_cnt_c  != CNT_W'(v_line_i.visible_area));
            frame_cnt_o  <= frame_cnt_o + FCNT_W'(1);
            frame_done_o <= 1'b1;
            first_pub    <= 1'b0;
            crc          <= CRC16_INIT;
            proto_err    <= de_i;
          end else if (de_i) begin
            crc <= crc16_step(crc, data_i);
          end
        end
        default: state <= A_IDLE;
      endcase
      if (!enable_i) begin
        state        <= A_IDLE;
        first_pub    <= 1'b1;
        proto_err    <= 1'b0;
        crc          <= CRC16_INIT;
        frame_done_o <= 1'b0;
        width_o      <= width_o;
        height_o     <= height_o;
        crc_o        <= crc_o;
        crc_match_o  <= crc_match_o;
        timing_err_o <= timing_err_o;
        frame_cnt_o  <= frame_cnt_o;
      end
    end
  end

endmodule
